// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//   Turns simple command requests into APB read/write transfers and returns a
//   one-cycle response pulse per accepted command.
//
// Parameters
//   BANK_ADDR  : psel width, one bit per target slave
//   DATA_WIDTH : pwdata / prdata / command data width
//   ADDR_WIDTH : paddr / command address width
//   TIMEOUT    : maximum number of ACCESS cycles with pready low (>= 1)
//
// Ports
//   pclk, preset        : clock (rising edge) and synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; accepted when both high at an edge
//   cmd_write/sel/addr/wdata : command fields, captured on acceptance
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata, rsp_err  : read data and error flag, valid with rsp_valid
//   psel, penable, pwrite, paddr, pwdata, prdata, pready : APB master side
// ---------------------------------------------------------------------------
module apb_master #(
  parameter int BANK_ADDR  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [BANK_ADDR-1:0]  cmd_sel,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [BANK_ADDR-1:0]  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count value held during the last ACCESS cycle still allowed to wait;
  // a low pready in that cycle brings the count to TIMEOUT and aborts.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;

  // The only combinational output: ready whenever idle and out of reset.
  assign cmd_ready = (state == IDLE) && !preset;

  // Single registered FSM. The response outputs default to zero every cycle
  // so rsp_valid is a pulse; the APB outputs hold their value through SETUP
  // and ACCESS and are cleared whenever the FSM returns to IDLE.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_sel != '0) begin
              state    <= SETUP;
              wait_cnt <= '0;
              psel     <= cmd_sel;
              penable  <= 1'b0;
              pwrite   <= cmd_write;
              paddr    <= cmd_addr;
              pwdata   <= cmd_write ? cmd_wdata : '0;
            end else begin
              // No target selected: answer with an error without a bus cycle.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end

        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end

        ACCESS: begin
          if (pready) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
          end else if (wait_cnt == LAST_WAIT) begin
            state     <= IDLE;
            wait_cnt  <= wait_cnt + CNT_W'(1);
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//   Self-checking bench for apb_master. A stimulus process issues commands,
//   a slave process answers on the APB side using a per-transaction wait
//   count and read value, and a monitor compares every bus phase and every
//   response against expectations computed from the transaction description.
// ---------------------------------------------------------------------------
module tb_apb_master;

  localparam int BANK_ADDR  = 2;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int TIMEOUT    = 15;

  logic                  pclk = 1'b0;
  logic                  preset;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [BANK_ADDR-1:0]  cmd_sel;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [BANK_ADDR-1:0]  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         len;
    int         lat;
    int         resp_cycle;
  } exp_t;

  typedef struct {
    logic [1:0] sel;
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
  } setup_t;

  typedef struct {
    int         waits;
    logic [7:0] rdata;
  } slave_t;

  exp_t   exp_q[$];
  setup_t setup_q[$];
  slave_t slave_q[$];

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  apb_master #(
    .BANK_ADDR (BANK_ADDR),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_sel  (cmd_sel),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cycle_cnt <= cycle_cnt + 1;

  // Safety net so the run always ends even if the design locks up.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  // Expected outcome of one command from the protocol rules:
  // no select -> immediate error; slave waits of TIMEOUT or more -> abort
  // after TIMEOUT ACCESS cycles; otherwise waits+1 ACCESS cycles and the
  // read value (or zero for writes). Latency counts cycles from the accept
  // edge to the cycle showing rsp_valid.
  function automatic exp_t model(input logic write, input logic [1:0] sel,
                                 input int waits, input logic [7:0] rdata);
    exp_t e;
    e.resp_cycle = 0;
    if (sel == 2'b00) begin
      e.err = 1'b1; e.rdata = 8'h00; e.len = 0; e.lat = 0;
    end else if (waits >= TIMEOUT) begin
      e.err = 1'b1; e.rdata = 8'h00; e.len = TIMEOUT; e.lat = TIMEOUT + 1;
    end else begin
      e.err = 1'b0; e.rdata = write ? 8'h00 : rdata; e.len = waits + 1;
      e.lat = waits + 2;
    end
    return e;
  endfunction

  task automatic randomizeIdleInputs();
    cmd_write = 1'($urandom);
    cmd_sel   = 2'($urandom);
    cmd_addr  = 3'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  // Presents one command (called just after a rising edge) and waits until
  // it is accepted, then records what the response must look like.
  task automatic applyStimulus(input logic write, input logic [1:0] sel,
                               input logic [2:0] addr, input logic [7:0] wdata,
                               input int waits, input logic [7:0] rdata,
                               input bit hold_valid, output int accept_cycle);
    exp_t e;
    bit   got;
    int   tries;
    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_sel   = sel;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    if (sel != 2'b00) begin
      setup_q.push_back('{sel, write, addr, write ? wdata : 8'h00});
      slave_q.push_back('{waits, rdata});
    end
    got   = 1'b0;
    tries = 0;
    while (!got && tries < 200) begin
      @(negedge pclk);
      got = cmd_ready;
      @(posedge pclk);
      #1;
      tries++;
    end
    checkOutput("accept", 32'(got), 32'd1);
    accept_cycle = cycle_cnt;
    e = model(write, sel, waits, rdata);
    e.resp_cycle = cycle_cnt + e.lat;
    exp_q.push_back(e);
    if (!hold_valid) begin
      cmd_valid = 1'b0;
      randomizeIdleInputs();
    end
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge pclk);
      #1;
      t++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // APB slave: answers each bus transfer after its scheduled number of wait
  // cycles, and drives junk on pready/prdata whenever they must be ignored.
  initial begin
    slave_t cur;
    bit     active;
    int     k;
    cur    = '{0, 8'h00};
    active = 1'b0;
    k      = 0;
    pready = 1'b0;
    prdata = 8'h00;
    forever begin
      @(posedge pclk);
      #1;
      if (preset || psel == 2'b00) begin
        active = 1'b0;
        pready = 1'($urandom);
        prdata = 8'($urandom);
      end else if (!penable) begin
        if (slave_q.size() > 0) begin
          cur    = slave_q.pop_front();
          active = 1'b1;
        end
        k      = 0;
        pready = 1'($urandom);
        prdata = 8'($urandom);
      end else begin
        pready = active && (k == cur.waits);
        prdata = pready ? cur.rdata : 8'($urandom);
        k++;
      end
    end
  end

  // Monitor: checks the SETUP phase fields, that ACCESS keeps them stable,
  // and every response against the scoreboard (value, ACCESS length, timing,
  // and the bus being back to idle).
  initial begin
    setup_t s;
    setup_t last_setup;
    exp_t   e;
    int     access_cnt;
    last_setup = '{2'b00, 1'b0, 3'h0, 8'h00};
    access_cnt = 0;
    forever begin
      @(negedge pclk);
      if (preset) begin
        access_cnt = 0;
      end else begin
        if (psel != 2'b00 && !penable) begin
          if (setup_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_setup: got psel %0h required no bus cycle", psel);
          end else begin
            s = setup_q.pop_front();
            last_setup = s;
            checkOutput("setup_bus", {psel, pwrite, paddr, pwdata},
                        {s.sel, s.write, s.addr, s.wdata});
          end
        end
        if (penable) begin
          access_cnt++;
          checkOutput("access_bus", {psel, pwrite, paddr, pwdata},
                      {last_setup.sel, last_setup.write, last_setup.addr, last_setup.wdata});
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid err %0b required none", rsp_err);
          end else begin
            e = exp_q.pop_front();
            checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
            checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            checkOutput("access_len", 32'(access_cnt), 32'(e.len));
            checkOutput("rsp_cycle", 32'(cycle_cnt), 32'(e.resp_cycle));
            checkOutput("idle_bus", {psel, penable, pwrite, paddr, pwdata}, 32'd0);
          end
          access_cnt = 0;
        end
      end
    end
  end

  // Main stimulus: reset, directed scenarios, then randomized traffic.
  initial begin
    int a1;
    int a2;
    int r;
    int w;
    int waits;
    logic [1:0] sel;
    bit hold;

    preset    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_sel   = 2'b00;
    cmd_addr  = 3'h1;
    cmd_wdata = 8'h3C;
    repeat (3) begin
      @(posedge pclk);
      #1;
    end
    @(negedge pclk);
    checkOutput("reset_ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset_outputs",
                {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    @(posedge pclk);
    #1;
    preset    = 1'b0;
    cmd_valid = 1'b0;
    @(negedge pclk);
    checkOutput("ready_after_reset", 32'(cmd_ready), 32'd1);
    @(posedge pclk);
    #1;

    $display("[TB] directed: zero-wait write");
    applyStimulus(1'b1, 2'b01, 3'h5, 8'hA5, 0, 8'h00, 1'b0, a1);
    $display("[TB] directed: read with 3 wait cycles");
    applyStimulus(1'b0, 2'b10, 3'h2, 8'h00, 3, 8'hF9, 1'b0, a1);
    $display("[TB] directed: read timeout");
    applyStimulus(1'b0, 2'b01, 3'h4, 8'h00, 40, 8'h77, 1'b0, a1);
    $display("[TB] directed: empty select");
    applyStimulus(1'b1, 2'b00, 3'h6, 8'h11, 0, 8'h00, 1'b0, a1);
    $display("[TB] directed: back-to-back writes");
    applyStimulus(1'b1, 2'b01, 3'h3, 8'h5A, 0, 8'h00, 1'b1, a1);
    applyStimulus(1'b1, 2'b10, 3'h7, 8'hC3, 0, 8'h00, 1'b0, a2);
    checkOutput("b2b_gap", 32'(a2 - a1), 32'd3);
    waitIdle();

    $display("[TB] directed: reset during ACCESS");
    applyStimulus(1'b0, 2'b10, 3'h1, 8'h00, 20, 8'h42, 1'b0, a1);
    @(posedge pclk);
    #1;
    @(posedge pclk);
    #1;
    preset = 1'b1;
    @(negedge pclk);
    checkOutput("ready_in_reset", 32'(cmd_ready), 32'd0);
    @(posedge pclk);
    #1;
    checkOutput("bus_after_reset", {psel, penable, pwrite, paddr, pwdata, rsp_valid}, 32'd0);
    preset = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge pclk);
    checkOutput("ready_after_midreset", 32'(cmd_ready), 32'd1);
    @(posedge pclk);
    #1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      sel = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
      w = $urandom_range(0, 9);
      waits = (w < 6) ? (w % 3) : (w == 6) ? TIMEOUT - 1 : (w == 7) ? TIMEOUT :
              (w == 8) ? TIMEOUT + 3 : $urandom_range(3, 8);
      hold = 1'($urandom);
      applyStimulus(1'($urandom), sel, 3'($urandom), 8'($urandom), waits,
                    8'($urandom), hold, a1);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge pclk);
          #1;
        end
      end
    end
    cmd_valid = 1'b0;
    waitIdle();
    checkOutput("setup_queue_empty", 32'(setup_q.size()), 32'd0);
    checkOutput("slave_queue_empty", 32'(slave_q.size()), 32'd0);

    repeat (3) @(posedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
